// File: rtl/led_pattern_gen_pkg.sv
// led_pat_pkg: mode encodings and width helpers shared by the LED pattern engine
package led_pat_pkg;
  localparam logic [2:0] MODE_OFF = 3'd0;
  localparam logic [2:0] MODE_ON = 3'd1;
  localparam logic [2:0] MODE_PWM = 3'd2;
  localparam logic [2:0] MODE_BLINK = 3'd3;
  localparam logic [2:0] MODE_BREATHE = 3'd4;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic int ch_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: configuration write port plus LED, period and error outputs
interface led_pattern_gen_if import led_pat_pkg::*; #(
  parameter int NUM_CH = 10,
  parameter int PWM_BITS = 8
) ();
  logic cfg_we;
  logic [ch_w(NUM_CH)-1:0] cfg_ch;
  logic [2:0] cfg_mode;
  logic [PWM_BITS-1:0] cfg_val;
  logic cfg_err;
  logic period;
  logic [NUM_CH-1:0] led;
  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_val, input cfg_err, period, led);
  modport slave (input cfg_we, cfg_ch, cfg_mode, cfg_val, output cfg_err, period, led);
endinterface

// File: rtl/led_pattern_gen_channel.sv
// led_channel: per-channel mode state, blink/breathe stepping and next LED value
module led_channel import led_pat_pkg::*; #(
  parameter int PWM_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [2:0] mode,
  input  logic [PWM_BITS-1:0] val,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic pend,
  output logic led_nxt
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [2:0] cur;
  logic [PWM_BITS-1:0] lim, bcnt, duty;
  logic phase, down;
  // a write restarts the channel dark and rising; it takes priority over the period step
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= MODE_OFF;
      lim <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      duty <= '0;
      down <= 1'b0;
    end else if (we) begin
      cur <= mode;
      lim <= val;
      bcnt <= '0;
      phase <= 1'b0;
      duty <= '0;
      down <= 1'b0;
    end else if (pend) begin
      if (cur == MODE_BLINK) begin
        bcnt <= (bcnt == lim) ? '0 : bcnt + 1'b1;
        phase <= phase ^ (bcnt == lim);
      end
      if (cur == MODE_BREATHE) begin
        duty <= (down ? duty == '0 : duty != MAX) ? duty + 1'b1 : duty - 1'b1;
        down <= down ? duty != '0 : duty == MAX;
      end
    end
  end
  // undefined modes fall through to dark
  always_comb begin
    led_nxt = (cur == MODE_ON) ? 1'b1 :
              (cur == MODE_PWM) ? pwm_cnt < lim :
              (cur == MODE_BLINK) ? phase :
              (cur == MODE_BREATHE) ? pwm_cnt < duty : 1'b0;
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel OFF/ON/PWM/BLINK/BREATHE LED engine with runtime config
module led_pattern_gen import led_pat_pkg::*; #(
  parameter int NUM_CH = 10,
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 390
) (
  input logic clk,
  input logic rst,
  led_pattern_gen_if.slave bus
);
  localparam int PW = cnt_w(TICK_DIV);
  localparam int CW = ch_w(NUM_CH);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [PW-1:0] pre;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic tick, pend;
  logic [NUM_CH-1:0] led_nxt;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign pend = tick && pwm_cnt == MAX;
  // timebase, error flag and registered LED drive
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      pwm_cnt <= '0;
      bus.period <= 1'b0;
      bus.cfg_err <= 1'b0;
      bus.led <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      pwm_cnt <= pwm_cnt + PWM_BITS'(tick);
      bus.period <= pend;
      bus.cfg_err <= bus.cfg_we && bus.cfg_ch >= CW'(NUM_CH);
      bus.led <= led_nxt;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk(clk),
      .rst(rst),
      .we(bus.cfg_we && bus.cfg_ch == CW'(i)),
      .mode(bus.cfg_mode),
      .val(bus.cfg_val),
      .pwm_cnt(pwm_cnt),
      .pend(pend),
      .led_nxt(led_nxt[i])
    );
  end
endmodule
